// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, oversampling
// constants and the baud divisor calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_e;

  localparam int unsigned OVS     = 16;
  localparam logic [3:0]  SMP_A   = 4'd7;
  localparam logic [3:0]  SMP_B   = 4'd8;
  localparam logic [3:0]  SMP_C   = 4'd9;
  localparam logic [3:0]  SC_LAST = 4'(OVS - 1);

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    int unsigned d;
    d = clk_hz / (OVS * baud);
    return (d == 0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_core_baud_tick.sv
// Oversampling tick generator: counts 0..DIV-1 while enabled, pulses tick on
// the last count, and sits at zero when disabled or cleared.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampled UART receiver with majority voting, optional parity and a
// single-entry valid/ready holding register with sticky overrun.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);

  logic       s1_q, s2_q;
  state_e     state_q, state_d;
  logic [3:0] sc_q, sc_d, sc_nx;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [1:0] smp_q, smp_d;
  logic       perr_q, perr_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d, ferr_q, ferr_d, perrh_q, perrh_d, ovr_q, ovr_d;
  logic       tick, vote, done, done_ferr;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .en   (state_q != IDLE),
    .clr  (rst),
    .tick (tick)
  );

  // Actions key on the value sc is about to take, so the third sample is
  // the live synchronised line and the first two come from smp_q.
  assign sc_nx = sc_q + 4'd1;
  assign vote  = (smp_q[0] & smp_q[1]) | (smp_q[0] & s2_q) | (smp_q[1] & s2_q);

  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    smp_d     = smp_q;
    perr_d    = perr_q;
    done      = 1'b0;
    done_ferr = 1'b0;
    if (tick) begin
      sc_d = sc_nx;
      if (sc_nx == SMP_A) smp_d[0] = s2_q;
      if (sc_nx == SMP_B) smp_d[1] = s2_q;
    end
    case (state_q)
      IDLE: begin
        if (!s2_q) begin
          state_d = START;
          sc_d    = '0;
          perr_d  = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (sc_nx == SMP_C && vote) begin
            state_d = IDLE;
            sc_d    = '0;
          end else if (sc_q == SC_LAST) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sc_nx == SMP_C) shreg_d = {vote, shreg_q[7:1]};
          if (sc_q == SC_LAST) begin
            if (bit_idx_q == 3'd7) begin
              if (PARITY_EN) state_d = PARITY;
              else           state_d = STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (sc_nx == SMP_C && (vote != (^shreg_q ^ PARITY_ODD))) perr_d = 1'b1;
          if (sc_q == SC_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && sc_nx == SMP_C) begin
          done      = 1'b1;
          done_ferr = ~vote;
          sc_d      = '0;
          if (vote) state_d = IDLE;
          else      state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (s2_q) begin
          state_d = IDLE;
          sc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        sc_d    = '0;
      end
    endcase
  end

  // A completed frame replaces the held byte only if the slot is empty or
  // is being drained on the same cycle; otherwise it is dropped.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perrh_d = perrh_q;
    ovr_d   = ovr_q;
    if (done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shreg_q;
        ferr_d  = done_ferr;
        perrh_d = perr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      state_q   <= IDLE;
      sc_q      <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      smp_q     <= '0;
      perr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perrh_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      s1_q      <= rx;
      s2_q      <= s1_q;
      state_q   <= state_d;
      sc_q      <= sc_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      smp_q     <= smp_d;
      perr_q    <= perr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perrh_q   <= perrh_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perrh_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule
